// File: rtl/pic_pkg.sv
// Shared types, widths and the lowest-set-bit helper for the INTA sequencer.
package pic_pkg;

    localparam int unsigned VEC_W   = 8;
    localparam int unsigned LVL_W   = 3;
    localparam int unsigned NUM_LVL = 8;
    localparam int unsigned BASE_W  = VEC_W - LVL_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        ACK1  = 3'd2,
        WAIT2 = 3'd3,
        VEC   = 3'd4
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [LVL_W-1:0] idx;
    } lowest_t;

    // Index of the lowest set bit (bit 0 = highest priority) plus a valid flag.
    function automatic lowest_t lowest_set8(input logic [NUM_LVL-1:0] v);
        lowest_t r;
        r.valid = 1'b0;
        r.idx   = '0;
        for (int i = NUM_LVL - 1; i >= 0; i--) begin
            if (v[i]) begin
                r.valid = 1'b1;
                r.idx   = LVL_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/inta_sequencer_if.sv
// CPU / priority-resolver facing bus of the INTA sequencer.
interface inta_sequencer_if;
    import pic_pkg::*;

    logic [NUM_LVL-1:0] irr_m;
    logic               isprior;
    logic               inta;
    logic               eoi;
    logic               eoi_sl;
    logic [LVL_W-1:0]   eoi_lvl;
    logic               aeoi;
    logic               int_o;
    logic [NUM_LVL-1:0] isr;
    logic [NUM_LVL-1:0] irr_clr;
    logic [VEC_W-1:0]   vec;
    logic               vec_oe;

    modport master (
        output irr_m, isprior, inta, eoi, eoi_sl, eoi_lvl, aeoi,
        input  int_o, isr, irr_clr, vec, vec_oe
    );

    modport slave (
        input  irr_m, isprior, inta, eoi, eoi_sl, eoi_lvl, aeoi,
        output int_o, isr, irr_clr, vec, vec_oe
    );

endinterface

// File: rtl/prio_enc8.sv
// Combinational lowest-index encoder over eight request/service bits.
module prio_enc8
    import pic_pkg::*;
(
    input  logic [NUM_LVL-1:0] in,
    output logic [LVL_W-1:0]   idx,
    output logic               valid
);

    lowest_t res;

    // Bit 0 wins; valid is low when no bit is set.
    always_comb begin
        res   = lowest_set8(in);
        idx   = res.idx;
        valid = res.valid;
    end

endmodule

// File: rtl/inta_sequencer.sv
// 8086-mode two-pulse INTA sequencer with ISR and EOI handling.
// Optional auto-EOI: define PIC_AEOI_EN to honour the aeoi input.
module inta_sequencer
    import pic_pkg::*;
#(
    parameter logic [BASE_W-1:0] VEC_BASE = 5'h08
) (
    input  logic              clk,
    input  logic              rst_n,
    inta_sequencer_if.slave   bus
);

    state_e             state_q, state_d;
    logic               inta_q;
    logic [LVL_W-1:0]   lvl_q, lvl_d;
    logic               spur_q, spur_d;
    logic               int_o_q, int_o_d;
    logic [NUM_LVL-1:0] isr_q, isr_d;
    logic [NUM_LVL-1:0] irr_clr_q, irr_clr_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic               vec_oe_q, vec_oe_d;

    logic [NUM_LVL-1:0] set_mask, clr_mask;
    logic [LVL_W-1:0]   ack_idx, eoi_idx;
    logic               ack_vld, eoi_vld;
    logic               inta_rise_c, inta_fall_c, ack_take_c, aeoi_clr_c;

    assign inta_rise_c = bus.inta & ~inta_q;
    assign inta_fall_c = ~bus.inta & inta_q;
    assign ack_take_c  = (state_q == REQ) && inta_rise_c;

    prio_enc8 u_ack_enc (.in(bus.irr_m), .idx(ack_idx), .valid(ack_vld));
    prio_enc8 u_eoi_enc (.in(isr_q),     .idx(eoi_idx), .valid(eoi_vld));

`ifdef PIC_AEOI_EN
    assign aeoi_clr_c = (state_q == VEC) && inta_fall_c && bus.aeoi && !spur_q;
`else
    logic unused_aeoi;
    assign unused_aeoi = bus.aeoi;
    assign aeoi_clr_c  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; ACK1 is a single-cycle hop into WAIT2.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.isprior && (|bus.irr_m)) state_d = REQ;
            REQ:     if (inta_rise_c)                 state_d = ACK1;
                     else if (!bus.isprior)           state_d = IDLE;
            ACK1:    state_d = WAIT2;
            WAIT2:   if (inta_rise_c)                 state_d = VEC;
            VEC:     if (inta_fall_c)                 state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values; an ACK set overrides a same-cycle EOI clear.
    always_comb begin
        lvl_d     = lvl_q;
        spur_d    = spur_q;
        irr_clr_d = '0;
        set_mask  = '0;
        clr_mask  = '0;
        if (ack_take_c) begin
            lvl_d  = ack_vld ? ack_idx : LVL_W'(7);
            spur_d = ~ack_vld;
            if (ack_vld) begin
                set_mask[ack_idx]  = 1'b1;
                irr_clr_d[ack_idx] = 1'b1;
            end
        end
        if (bus.eoi) begin
            if (bus.eoi_sl)   clr_mask[bus.eoi_lvl] = 1'b1;
            else if (eoi_vld) clr_mask[eoi_idx]     = 1'b1;
        end
        if (aeoi_clr_c) clr_mask[lvl_q] = 1'b1;
        isr_d    = (isr_q & ~clr_mask) | set_mask;
        int_o_d  = (state_d == REQ);
        vec_oe_d = (state_d == VEC);
        vec_d    = vec_oe_d ? {VEC_BASE, lvl_d} : '0;
    end

    // Registered outputs, INTA edge history and latched level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inta_q    <= 1'b0;
            lvl_q     <= '0;
            spur_q    <= 1'b0;
            int_o_q   <= 1'b0;
            isr_q     <= '0;
            irr_clr_q <= '0;
            vec_q     <= '0;
            vec_oe_q  <= 1'b0;
        end else begin
            inta_q    <= bus.inta;
            lvl_q     <= lvl_d;
            spur_q    <= spur_d;
            int_o_q   <= int_o_d;
            isr_q     <= isr_d;
            irr_clr_q <= irr_clr_d;
            vec_q     <= vec_d;
            vec_oe_q  <= vec_oe_d;
        end
    end

    assign bus.int_o   = int_o_q;
    assign bus.isr     = isr_q;
    assign bus.irr_clr = irr_clr_q;
    assign bus.vec     = vec_q;
    assign bus.vec_oe  = vec_oe_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Self-checking bench for inta_sequencer: per-scenario tasks plus a vector scoreboard.
module tb_inta_sequencer;
    import pic_pkg::*;

    localparam logic [4:0] VB = 5'h08;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inta_sequencer_if bus();

    inta_sequencer #(.VEC_BASE(VB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    logic       oe_prev = 1'b0;

    // Scoreboard: every rising vec_oe must match the oldest expected vector.
    always @(negedge clk) begin
        if (bus.vec_oe === 1'b1 && oe_prev !== 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL vec_unexpected got %h required none", bus.vec);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.vec !== mon_exp) begin
                    errors++;
                    $display("FAIL vec got %h required %h", bus.vec, mon_exp);
                end
            end
        end
        oe_prev = bus.vec_oe;
    end

    function automatic logic [7:0] exp_vec(input logic [7:0] irr);
        for (int i = 0; i < 8; i++)
            if (irr[i]) return {VB, 3'(i)};
        return {VB, 3'd7};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.irr_m = '0; bus.isprior = 1'b0; bus.inta = 1'b0;
        bus.eoi = 1'b0; bus.eoi_sl = 1'b0; bus.eoi_lvl = '0; bus.aeoi = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_int(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.int_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Full request + two-pulse acknowledge; irr_ack is what irr_m shows at the first pulse.
    task automatic ack_seq(input logic [7:0] irr_req, input logic [7:0] irr_ack, output bit ok);
        bus.irr_m = irr_req; bus.isprior = 1'b1;
        wait_int(ok);
        bus.irr_m = irr_ack;
        if (ok) exp_q.push_back(exp_vec(irr_ack));
        bus.inta = 1'b1; step(); bus.inta = 1'b0; step();
        bus.inta = 1'b1; step(); bus.inta = 1'b0; step();
        bus.isprior = 1'b0; bus.irr_m = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step(); step();
        checks++;
        if ({bus.int_o, bus.isr, bus.irr_clr, bus.vec, bus.vec_oe} !== 26'd0) begin
            errors++;
            $display("FAIL reset_hold got int=%b isr=%h clr=%h vec=%h oe=%b required all 0",
                     bus.int_o, bus.isr, bus.irr_clr, bus.vec, bus.vec_oe);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({bus.int_o, bus.isr, bus.irr_clr, bus.vec, bus.vec_oe} !== 26'd0) begin
            errors++;
            $display("FAIL reset_release got int=%b isr=%h oe=%b required all 0",
                     bus.int_o, bus.isr, bus.vec_oe);
        end
    endtask

    task automatic test_basic();
        bus.irr_m = 8'b0010_1000; bus.isprior = 1'b1;
        checks++;
        if (bus.int_o !== 1'b0) begin errors++; $display("FAIL basic_int_early got %b required 0", bus.int_o); end
        step();
        checks++;
        if (bus.int_o !== 1'b1) begin errors++; $display("FAIL basic_int got %b required 1", bus.int_o); end
        exp_q.push_back(8'h43);
        bus.inta = 1'b1; step();
        checks++;
        if (bus.isr !== 8'h08 || bus.irr_clr !== 8'h08 || bus.int_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_ack1 got isr=%h clr=%h int=%b required 08 08 0", bus.isr, bus.irr_clr, bus.int_o);
        end
        bus.inta = 1'b0; step();
        checks++;
        if (bus.irr_clr !== 8'h00 || bus.isr !== 8'h08) begin
            errors++;
            $display("FAIL basic_clr_pulse got clr=%h isr=%h required 00 08", bus.irr_clr, bus.isr);
        end
        bus.inta = 1'b1; step();
        checks++;
        if (bus.vec_oe !== 1'b1 || bus.vec !== 8'h43) begin
            errors++;
            $display("FAIL basic_vec got oe=%b vec=%h required 1 43", bus.vec_oe, bus.vec);
        end
        bus.inta = 1'b0; step();
        checks++;
        if (bus.vec_oe !== 1'b0) begin errors++; $display("FAIL basic_vec_drop got %b required 0", bus.vec_oe); end
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL basic_sb got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bus.irr_m = 8'h20; bus.isprior = 1'b1;
        step();
        checks++;
        if (bus.int_o !== 1'b1) begin errors++; $display("FAIL b2b_int got %b required 1", bus.int_o); end
        ack_seq(8'h20, 8'h20, ok);
        checks++;
        if (!ok || bus.isr !== 8'h28) begin
            errors++;
            $display("FAIL b2b_isr got ok=%b isr=%h required 1 28", ok, bus.isr);
        end
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_sb got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_spurious();
        bit ok;
        do_reset();
        ack_seq(8'h02, 8'h02, ok);
        bus.irr_m = 8'h10; bus.isprior = 1'b1;
        wait_int(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL spur_int got 0 required 1"); end
        bus.irr_m = 8'h00;
        if (ok) exp_q.push_back(8'h47);
        bus.inta = 1'b1; step();
        checks++;
        if (bus.isr !== 8'h02 || bus.irr_clr !== 8'h00) begin
            errors++;
            $display("FAIL spur_ack1 got isr=%h clr=%h required 02 00", bus.isr, bus.irr_clr);
        end
        bus.inta = 1'b0; step(); bus.inta = 1'b1; step(); bus.inta = 1'b0; step();
        bus.isprior = 1'b0;
        checks++;
        if (bus.isr !== 8'h02) begin errors++; $display("FAIL spur_isr got %h required 02", bus.isr); end
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL spur_sb got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_eoi();
        bit ok1, ok2;
        do_reset();
        ack_seq(8'h20, 8'h20, ok1);
        ack_seq(8'h80, 8'h80, ok2);
        checks++;
        if (!ok1 || !ok2 || bus.isr !== 8'b1010_0000) begin
            errors++;
            $display("FAIL eoi_setup got isr=%h required a0", bus.isr);
        end
        bus.eoi = 1'b1; bus.eoi_sl = 1'b0; step(); bus.eoi = 1'b0;
        checks++;
        if (bus.isr !== 8'b1000_0000) begin errors++; $display("FAIL eoi_nonspec got %h required 80", bus.isr); end
        bus.eoi = 1'b1; bus.eoi_sl = 1'b1; bus.eoi_lvl = 3'd7; step(); bus.eoi = 1'b0;
        checks++;
        if (bus.isr !== 8'h00) begin errors++; $display("FAIL eoi_spec got %h required 00", bus.isr); end
        bus.eoi = 1'b1; bus.eoi_sl = 1'b0; step(); bus.eoi = 1'b0;
        checks++;
        if (bus.isr !== 8'h00) begin errors++; $display("FAIL eoi_empty got %h required 00", bus.isr); end
    endtask

    task automatic test_aeoi();
        bit ok;
        logic [7:0] want;
`ifdef PIC_AEOI_EN
        want = 8'h00;
`else
        want = 8'h04;
`endif
        do_reset();
        bus.aeoi = 1'b1; bus.irr_m = 8'h04; bus.isprior = 1'b1;
        wait_int(ok);
        if (ok) exp_q.push_back(8'h42);
        bus.inta = 1'b1; step(); bus.inta = 1'b0; step();
        checks++;
        if (!ok || bus.isr !== 8'h04) begin errors++; $display("FAIL aeoi_between got isr=%h required 04", bus.isr); end
        bus.inta = 1'b1; step(); bus.inta = 1'b0; step();
        bus.isprior = 1'b0; bus.irr_m = '0;
        checks++;
        if (bus.isr !== want) begin errors++; $display("FAIL aeoi_after got %h required %h", bus.isr, want); end
        bus.aeoi = 1'b0;
    endtask

    task automatic test_collision();
        bit ok;
        do_reset();
        bus.irr_m = 8'h08; bus.isprior = 1'b1;
        wait_int(ok);
        if (ok) exp_q.push_back(8'h43);
        bus.inta = 1'b1; bus.eoi = 1'b1; bus.eoi_sl = 1'b1; bus.eoi_lvl = 3'd3;
        step();
        bus.eoi = 1'b0;
        checks++;
        if (!ok || bus.isr !== 8'h08 || bus.irr_clr !== 8'h08) begin
            errors++;
            $display("FAIL collision got isr=%h clr=%h required 08 08", bus.isr, bus.irr_clr);
        end
        bus.inta = 1'b0; step(); bus.inta = 1'b1; step(); bus.inta = 1'b0; step();
        bus.isprior = 1'b0; bus.irr_m = '0;
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL collision_sb got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_cancel();
        bit ok;
        do_reset();
        bus.irr_m = 8'h01; bus.isprior = 1'b1;
        wait_int(ok);
        bus.isprior = 1'b0;
        step();
        checks++;
        if (!ok || bus.int_o !== 1'b0) begin errors++; $display("FAIL cancel_int got %b required 0", bus.int_o); end
        bus.inta = 1'b1; step(); bus.inta = 1'b0; step();
        bus.inta = 1'b1; step(); bus.inta = 1'b0; step();
        checks++;
        if (bus.isr !== 8'h00 || bus.vec_oe !== 1'b0) begin
            errors++;
            $display("FAIL cancel_idle_inta got isr=%h oe=%b required 00 0", bus.isr, bus.vec_oe);
        end
        bus.irr_m = '0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        bus.irr_m = 8'h40; bus.isprior = 1'b1;
        wait_int(ok);
        bus.inta = 1'b1; step(); bus.inta = 1'b0; step();
        checks++;
        if (!ok || bus.isr !== 8'h40) begin errors++; $display("FAIL rstmid_setup got isr=%h required 40", bus.isr); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.int_o, bus.isr, bus.irr_clr, bus.vec, bus.vec_oe} !== 26'd0) begin
            errors++;
            $display("FAIL rstmid_clear got int=%b isr=%h clr=%h vec=%h oe=%b required all 0",
                     bus.int_o, bus.isr, bus.irr_clr, bus.vec, bus.vec_oe);
        end
        idle_inputs();
        step();
        rst_n = 1'b1;
        step();
        bus.inta = 1'b1; step(); bus.inta = 1'b0; step();
        checks++;
        if (bus.isr !== 8'h00 || bus.vec_oe !== 1'b0 || bus.vec !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_novec got isr=%h oe=%b vec=%h required 00 0 00", bus.isr, bus.vec_oe, bus.vec);
        end
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL rstmid_sb got %0d pending required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_spurious();
        test_eoi();
        test_aeoi();
        test_collision();
        test_cancel();
        test_reset_mid();
        step(); step();
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL final_sb got %0d pending required 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
